// File: rtl/uart_rx_oversampled_if.sv
// uart_rx_oversampled_if
//   Receive-side bundle of the UART receiver: the deframed byte, its
//   completion pulse, the per-frame error flags and the busy indicator.
//   master : driven by the receiver (uart_rx_oversampled)
//   slave  : consumed by the user logic
//   Signals
//     RX_Data      [7:0] last received byte
//     Valid_rx           one-cycle pulse, frame complete
//     Parity_error       parity mismatch of the last flagged frame
//     Stop_error         stop bit sampled low in the last flagged frame
//     Busy_rx            receiver is inside a frame
interface uart_rx_oversampled_if;
    logic [7:0] RX_Data;
    logic       Valid_rx;
    logic       Parity_error;
    logic       Stop_error;
    logic       Busy_rx;

    modport master (
        output RX_Data,
        output Valid_rx,
        output Parity_error,
        output Stop_error,
        output Busy_rx
    );

    modport slave (
        input RX_Data,
        input Valid_rx,
        input Parity_error,
        input Stop_error,
        input Busy_rx
    );
endinterface

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled
//   UART receiver with an internal 16x (OVERSAMPLE) tick derived from clk.
//   Deframes start, 8 data bits LSB-first, optional even parity and one
//   stop bit. Each completed frame pulses Valid_rx for one clk together
//   with updated RX_Data / Parity_error / Stop_error; the byte and flags
//   hold until the next frame completes. A low stop bit (framing error or
//   break) parks the receiver until the line returns high.
//   Build option: define UART_RX_PARITY_EN for 8E1 framing; otherwise the
//   frame is 8N1 and Parity_error stays 0.
//   Ports
//     clk    system clock, rising edge
//     reset  synchronous, active-high
//     RXD    asynchronous serial line, idle high
//     rx     uart_rx_oversampled_if.master outputs
module uart_rx_oversampled #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         RXD,
    uart_rx_oversampled_if.master        rx
);
    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SMP_W   = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [SMP_W-1:0] SMP_MID  = SMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t             state, state_next;
    logic               rxd_p0, rxd_p1;
    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    logic [SMP_W-1:0]   smp_cnt, smp_next;
    logic [2:0]         bit_idx, bit_next;
    logic [7:0]         shift, shift_next;
    logic               par_pend, par_next;
    logic               load, stop_bad;

    logic [7:0]         data_q;
    logic               valid_q, perr_q, serr_q;

    // Sync stage: two flops, idle-high reset so no false start after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
        end else begin
            rxd_p0 <= RXD;
            rxd_p1 <= rxd_p0;
        end
    end

    // Tick divider held at zero in IDLE so tick phase starts at the edge
    assign tick = (state != IDLE) && (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset || state == IDLE || tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DIV_W'(1);
    end

    always_comb begin
        state_next = state;
        smp_next   = smp_cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        par_next   = par_pend;
        load       = 1'b0;
        stop_bad   = 1'b0;

        if (tick)
            smp_next = smp_cnt + SMP_W'(1);

        case (state)
            IDLE: begin
                smp_next = '0;
                par_next = 1'b0;
                if (!rxd_p1)
                    state_next = START;
            end
            START: begin
                if (tick && smp_cnt == SMP_MID) begin
                    smp_next = '0;
                    if (rxd_p1) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                        bit_next   = 3'd0;
                    end
                end
            end
            DATA: begin
                if (tick && smp_cnt == SMP_LAST) begin
                    smp_next   = '0;
                    shift_next = {rxd_p1, shift[7:1]};
                    bit_next   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick && smp_cnt == SMP_LAST) begin
                    smp_next   = '0;
                    // Even parity: data bits plus parity bit must XOR to 0
                    par_next   = rxd_p1 ^ (^shift);
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (tick && smp_cnt == SMP_LAST) begin
                    smp_next   = '0;
                    load       = 1'b1;
                    stop_bad   = !rxd_p1;
                    state_next = rxd_p1 ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                smp_next = '0;
                if (rxd_p1)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame stage: state, counters and captured byte
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            smp_cnt  <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            par_pend <= 1'b0;
        end else begin
            state    <= state_next;
            smp_cnt  <= smp_next;
            bit_idx  <= bit_next;
            shift    <= shift_next;
            par_pend <= par_next;
        end
    end

    // Output stage: byte and flags update only on frame completion
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            valid_q <= load;
            if (load) begin
                data_q <= shift;
                perr_q <= par_pend;
                serr_q <= stop_bad;
            end
        end
    end

    assign rx.RX_Data      = data_q;
    assign rx.Valid_rx     = valid_q;
    assign rx.Parity_error = perr_q;
    assign rx.Stop_error   = serr_q;
    assign rx.Busy_rx      = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled
//   Directed bench for uart_rx_oversampled at DIV=10 (160 clk per bit).
//   Works for both 8N1 and 8E1 builds (UART_RX_PARITY_EN).
module tb_uart_rx_oversampled;
    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int OS       = 16;
    localparam int BIT      = 160;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_EN   = 1;
`else
    localparam int PAR_EN   = 0;
`endif
    // edge -> Valid_rx: 3 clk detection + 9.5 (or 10.5) bit periods
    localparam int LAT_EXP  = 3 + 1520 + PAR_EN * BIT;

    logic clk = 1'b0;
    logic reset;
    logic RXD;

    always #5 clk = ~clk;

    uart_rx_oversampled_if rx_if ();

    uart_rx_oversampled #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD),
        .OVERSAMPLE (OS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .RXD   (RXD),
        .rx    (rx_if)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int edge_cyc = 0;
    int dbl   = 0;
    logic prev_v = 1'b0;

    logic [7:0] got_d[$];
    logic       got_p[$];
    logic       got_s[$];
    int         got_c[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every completed frame; flag back-to-back Valid_rx cycles
    always @(negedge clk) begin
        if (rx_if.Valid_rx) begin
            got_d.push_back(rx_if.RX_Data);
            got_p.push_back(rx_if.Parity_error);
            got_s.push_back(rx_if.Stop_error);
            got_c.push_back(cyc);
            if (prev_v) dbl <= dbl + 1;
        end
        prev_v <= rx_if.Valid_rx;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        got_d.delete();
        got_p.delete();
        got_s.delete();
        got_c.delete();
    endtask

    function automatic logic [7:0] fd(input int i);
        return (i < got_d.size()) ? got_d[i] : 8'hxx;
    endfunction
    function automatic logic fp(input int i);
        return (i < got_p.size()) ? got_p[i] : 1'bx;
    endfunction
    function automatic logic fs(input int i);
        return (i < got_s.size()) ? got_s[i] : 1'bx;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame from the current negedge; leaves RXD at stop_v
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop_v);
        RXD = 1'b0;
        edge_cyc = cyc;
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            RXD = d[i];
            wait_clk(BIT);
        end
        if (PAR_EN != 0) begin
            RXD = (^d) ^ bad_par;
            wait_clk(BIT);
        end
        RXD = stop_v;
        wait_clk(BIT);
    endtask

    initial begin
        int lat;
        logic [7:0] c3;
        reset = 1'b1;
        RXD   = 1'b1;
        wait_clk(5);
        chk("rst_data",  rx_if.RX_Data, 8'h00);
        chk("rst_valid", rx_if.Valid_rx, 1'b0);
        chk("rst_perr",  rx_if.Parity_error, 1'b0);
        chk("rst_serr",  rx_if.Stop_error, 1'b0);
        chk("rst_busy",  rx_if.Busy_rx, 1'b0);
        reset = 1'b0;
        wait_clk(20);
        chk("idle_busy", rx_if.Busy_rx, 1'b0);

        // Single frame 0xA5 with latency check
        clear_log();
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_clk(BIT);
        chk("a5_count", got_d.size(), 1);
        chk("a5_data",  fd(0), 8'hA5);
        chk("a5_perr",  fp(0), 1'b0);
        chk("a5_serr",  fs(0), 1'b0);
        lat = (got_c.size() > 0) ? got_c[0] - edge_cyc : -1;
        chk("a5_latency_ok", (lat >= LAT_EXP - 3 && lat <= LAT_EXP + 3), 1'b1);
        chk("a5_hold",  rx_if.RX_Data, 8'hA5);

        // Back-to-back frames, no idle gap
        clear_log();
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b1);
        wait_clk(BIT);
        chk("b2b_count", got_d.size(), 3);
        chk("b2b_d0", fd(0), 8'h00);
        chk("b2b_d1", fd(1), 8'hFF);
        chk("b2b_d2", fd(2), 8'h3C);
        chk("b2b_flags", {fp(0), fs(0), fp(1), fs(1), fp(2), fs(2)}, 6'b0);

`ifdef UART_RX_PARITY_EN
        // Inverted parity bit, then a good frame clears the flag
        clear_log();
        send_frame(8'h55, 1'b1, 1'b1);
        send_frame(8'h55, 1'b0, 1'b1);
        wait_clk(BIT);
        chk("par_count", got_d.size(), 2);
        chk("par_bad_data", fd(0), 8'h55);
        chk("par_bad_flag", fp(0), 1'b1);
        chk("par_good_flag", fp(1), 1'b0);
`endif
        chk("perr_now", rx_if.Parity_error, 1'b0);

        // Stop bit low followed by a 3-bit break
        clear_log();
        send_frame(8'h81, 1'b0, 1'b0);
        wait_clk(3 * BIT);
        chk("brk_count", got_d.size(), 1);
        chk("brk_data",  fd(0), 8'h81);
        chk("brk_serr",  fs(0), 1'b1);
        chk("brk_busy",  rx_if.Busy_rx, 1'b1);
        RXD = 1'b1;
        wait_clk(2 * BIT);
        chk("brk_count_after", got_d.size(), 1);
        chk("brk_idle", rx_if.Busy_rx, 1'b0);
        send_frame(8'h42, 1'b0, 1'b1);
        wait_clk(BIT);
        chk("post_brk_count", got_d.size(), 2);
        chk("post_brk_data",  fd(1), 8'h42);
        chk("post_brk_serr",  fs(1), 1'b0);

        // 60-clk glitch on the idle line
        clear_log();
        RXD = 1'b0;
        wait_clk(30);
        chk("glitch_busy_hi", rx_if.Busy_rx, 1'b1);
        wait_clk(30);
        RXD = 1'b1;
        wait_clk(70);
        chk("glitch_busy_lo", rx_if.Busy_rx, 1'b0);
        chk("glitch_count", got_d.size(), 0);

        // Reset in the middle of data bit 4 of 0xC3
        clear_log();
        c3 = 8'hC3;
        RXD = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 4; i++) begin
            RXD = c3[i];
            wait_clk(BIT);
        end
        RXD = c3[4];
        wait_clk(BIT / 2);
        reset = 1'b1;
        RXD   = 1'b1;
        wait_clk(3);
        chk("mid_rst_data",  rx_if.RX_Data, 8'h00);
        chk("mid_rst_valid", rx_if.Valid_rx, 1'b0);
        chk("mid_rst_busy",  rx_if.Busy_rx, 1'b0);
        chk("mid_rst_serr",  rx_if.Stop_error, 1'b0);
        reset = 1'b0;
        wait_clk(2 * BIT);
        chk("mid_rst_count", got_d.size(), 0);
        send_frame(8'h18, 1'b0, 1'b1);
        wait_clk(BIT);
        chk("after_rst_count", got_d.size(), 1);
        chk("after_rst_data",  fd(0), 8'h18);
        chk("after_rst_flags", {fp(0), fs(0)}, 2'b00);

        chk("no_double_valid", dbl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
